// File: rtl/regaddr_hazard_pkg.sv
// Shared types and constants for the register-address hazard scanner.
package regaddr_hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } scan_state_e;

endpackage

// File: rtl/regaddr_hazard_scanner_comparator.sv
// Single 5-bit register-address equality comparator, shared across table slots.
module comparator
  import regaddr_hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] a_i,
  input  logic [REG_ADDR_W-1:0] b_i,
  output logic                  eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/regaddr_hazard_scanner.sv
// Valid-tagged table of in-flight destination registers; hazard lookups walk the
// table one slot per cycle through a single shared comparator.
module regaddr_hazard_scanner
  import regaddr_hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [REG_ADDR_W-1:0] alloc_addr_i,
  output logic [IDXW-1:0]       alloc_idx_o,

  input  logic                  release_valid_i,
  input  logic [IDXW-1:0]       release_idx_i,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [REG_ADDR_W-1:0] req_addr_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [IDXW-1:0]       rsp_idx_o,

  output logic                  busy_o
);

  scan_state_e           state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  hit_q, hit_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [REG_ADDR_W-1:0] tab_q [DEPTH];

  logic [IDXW-1:0]       free_idx;
  logic                  any_free;
  logic                  alloc_fire;
  logic                  rel_at_ptr;
  logic                  eff_valid;
  logic                  cmp_eq;

  // Lowest free slot, taken from the table state before this cycle's release.
  always_comb begin
    free_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDXW'(i);
      end
    end
  end

  assign any_free      = ~&valid_q;
  assign alloc_ready_o = any_free && (state_q == IDLE);
  assign alloc_idx_o   = free_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  // A release landing on the slot under examination masks it this same cycle.
  assign rel_at_ptr = release_valid_i && (release_idx_i == ptr_q);
  assign eff_valid  = valid_q[ptr_q] && !rel_at_ptr;

  comparator u_cmp (
    .a_i  (addr_q),
    .b_i  (tab_q[ptr_q]),
    .eq_o (cmp_eq)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    addr_d      = addr_q;
    req_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d = req_addr_i;
          if ((req_addr_i == REG_X0) || (valid_q == '0)) begin
            hit_d   = 1'b0;
            idx_d   = '0;
            state_d = RESP;
          end else begin
            ptr_d   = '0;
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (eff_valid && cmp_eq) begin
          hit_d   = 1'b1;
          idx_d   = ptr_q;
          state_d = RESP;
        end else if (ptr_q == IDXW'(DEPTH - 1)) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = RESP;
        end else begin
          ptr_d = ptr_q + IDXW'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Release clears first so an alloc into a just-freed index is never undone.
  always_comb begin
    valid_d = valid_q;
    if (release_valid_i) begin
      valid_d[release_idx_i] = 1'b0;
    end
    if (alloc_fire) begin
      valid_d[free_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Address payload needs no reset; it is only read behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      tab_q[free_idx] <= alloc_addr_i;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_hit_o   = hit_q;
  assign rsp_idx_o   = idx_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_regaddr_hazard_scanner.sv
// Directed, table-driven bench for regaddr_hazard_scanner at DEPTH=4.
module tb_regaddr_hazard_scanner;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDXW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alloc_valid = 1'b0;
  logic            alloc_ready;
  logic [4:0]      alloc_addr = '0;
  logic [IDXW-1:0] alloc_idx;
  logic            release_valid = 1'b0;
  logic [IDXW-1:0] release_idx = '0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      req_addr = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic            rsp_hit;
  logic [IDXW-1:0] rsp_idx;
  logic            busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regaddr_hazard_scanner #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .alloc_valid_i   (alloc_valid),
    .alloc_ready_o   (alloc_ready),
    .alloc_addr_i    (alloc_addr),
    .alloc_idx_o     (alloc_idx),
    .release_valid_i (release_valid),
    .release_idx_i   (release_idx),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_hit_o       (rsp_hit),
    .rsp_idx_o       (rsp_idx),
    .busy_o          (busy)
  );

  typedef enum int {OpLook, OpAlloc, OpRel, OpAllocRel, OpChk} op_e;

  typedef struct {
    op_e op;
    int  addr;
    int  idx;   // expected alloc/rsp index
    int  rel;   // release index
    int  hit;   // expected hit (OpLook) or alloc_ready (OpChk)
    int  lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, int addr, int idx, int rel, int hit, int lat);
    vec_t v;
    v.op = op; v.addr = addr; v.idx = idx; v.rel = rel; v.hit = hit; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_rsp(input int start, output int lat);
    bit done;
    lat  = start;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        check("scan_busy", int'(busy), 1);
        check("scan_alloc_blocked", int'(alloc_ready), 0);
        if (lat >= 20) begin
          check("rsp_timeout", lat, -1);
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
          lat++;
        end
      end
    end
  endtask

  task automatic do_lookup(input int addr, input int hit, input int idx, input int lat);
    int got_lat;
    req_valid = 1'b1;
    req_addr  = 5'(addr);
    @(negedge clk);
    check("req_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(1, got_lat);
    check($sformatf("lat_%0d", addr), got_lat, lat);
    check($sformatf("hit_%0d", addr), int'(rsp_hit), hit);
    check($sformatf("idx_%0d", addr), int'(rsp_idx), idx);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_alloc(input int addr, input int idx, input bit with_rel, input int rel);
    alloc_valid   = 1'b1;
    alloc_addr    = 5'(addr);
    release_valid = with_rel;
    release_idx   = IDXW'(rel);
    @(negedge clk);
    check("alloc_ready", int'(alloc_ready), 1);
    check("alloc_idx", int'(alloc_idx), idx);
    @(posedge clk); #1;
    alloc_valid   = 1'b0;
    release_valid = 1'b0;
  endtask

  task automatic do_release(input int rel);
    release_valid = 1'b1;
    release_idx   = IDXW'(rel);
    @(posedge clk); #1;
    release_valid = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  rose;

    vecs.push_back(mk(OpLook,     7, 0, 0, 0, 1));
    vecs.push_back(mk(OpAlloc,    3, 0, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    9, 1, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    3, 2, 0, 0, 0));
    vecs.push_back(mk(OpLook,     3, 0, 0, 1, 2));
    vecs.push_back(mk(OpLook,     9, 1, 0, 1, 3));
    vecs.push_back(mk(OpLook,    31, 0, 0, 0, 5));
    vecs.push_back(mk(OpLook,     0, 0, 0, 0, 1));
    vecs.push_back(mk(OpRel,      0, 0, 0, 0, 0));
    vecs.push_back(mk(OpRel,      0, 0, 1, 0, 0));
    vecs.push_back(mk(OpRel,      0, 0, 2, 0, 0));
    vecs.push_back(mk(OpLook,     3, 0, 0, 0, 1));
    vecs.push_back(mk(OpAlloc,    1, 0, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    2, 1, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    4, 2, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    8, 3, 0, 0, 0));
    vecs.push_back(mk(OpChk,      0, 0, 0, 0, 0));
    vecs.push_back(mk(OpLook,    31, 0, 0, 0, 5));
    vecs.push_back(mk(OpLook,     8, 3, 0, 1, 5));
    vecs.push_back(mk(OpLook,     2, 1, 0, 1, 3));
    vecs.push_back(mk(OpRel,      0, 0, 0, 0, 0));
    vecs.push_back(mk(OpAllocRel, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OpChk,      0, 1, 0, 1, 0));
    vecs.push_back(mk(OpLook,     0, 0, 0, 0, 1));
    vecs.push_back(mk(OpLook,     4, 2, 0, 1, 4));
    vecs.push_back(mk(OpLook,     2, 0, 0, 0, 5));
    vecs.push_back(mk(OpRel,      0, 0, 0, 0, 0));
    vecs.push_back(mk(OpRel,      0, 0, 2, 0, 0));
    vecs.push_back(mk(OpRel,      0, 0, 3, 0, 0));
    vecs.push_back(mk(OpRel,      0, 0, 1, 0, 0));
    vecs.push_back(mk(OpChk,      0, 0, 0, 1, 0));
    vecs.push_back(mk(OpAlloc,    5, 0, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    6, 1, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    7, 2, 0, 0, 0));
    vecs.push_back(mk(OpAlloc,    6, 3, 0, 0, 0));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_hit", int'(rsp_hit), 0);
    check("rst_rsp_idx", int'(rsp_idx), 0);
    check("rst_alloc_ready", int'(alloc_ready), 1);
    check("rst_alloc_idx", int'(alloc_idx), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      unique case (vecs[i].op)
        OpLook:     do_lookup(vecs[i].addr, vecs[i].hit, vecs[i].idx, vecs[i].lat);
        OpAlloc:    do_alloc(vecs[i].addr, vecs[i].idx, 1'b0, 0);
        OpAllocRel: do_alloc(vecs[i].addr, vecs[i].idx, 1'b1, vecs[i].rel);
        OpRel:      do_release(vecs[i].rel);
        OpChk: begin
          @(negedge clk);
          check($sformatf("chk_alloc_ready_v%0d", i), int'(alloc_ready), vecs[i].hit);
          if (vecs[i].hit != 0) begin
            check($sformatf("chk_alloc_idx_v%0d", i), int'(alloc_idx), vecs[i].idx);
          end
          @(posedge clk); #1;
        end
        default: ;
      endcase
    end

    // Table {5,6,7,6}: release slot 1 in the cycle it is examined, then stall the response.
    req_valid = 1'b1;
    req_addr  = 5'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    release_valid = 1'b1;
    release_idx   = 2'd1;
    @(posedge clk); #1;
    release_valid = 1'b0;
    wait_rsp(3, lat);
    check("mask_lat", lat, 5);
    check("mask_hit", int'(rsp_hit), 1);
    check("mask_idx", int'(rsp_idx), 3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", int'(rsp_valid), 1);
      check("hold_hit", int'(rsp_hit), 1);
      check("hold_idx", int'(rsp_idx), 3);
      check("hold_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_valid", int'(rsp_valid), 0);
    check("post_alloc_ready", int'(alloc_ready), 1);
    check("post_alloc_idx", int'(alloc_idx), 1);
    @(posedge clk); #1;
    do_alloc(9, 1, 1'b0, 0);

    // Reset in the middle of a scan over a full table.
    req_valid = 1'b1;
    req_addr  = 5'd31;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrst_busy", int'(busy), 0);
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_alloc_ready", int'(alloc_ready), 1);
    check("midrst_alloc_idx", int'(alloc_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rose = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) rose = 1'b1;
    end
    check("midrst_no_rsp", int'(rose), 0);
    @(posedge clk); #1;
    do_alloc(12, 0, 1'b0, 0);
    do_lookup(12, 1, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
